oam_dma_ctrl: RTL and testbench

//  Sprite-RAM DMA sequencer and CPU/memory bus arbiter, sitting between the CPU and mem_top.
//  A CPU write to the DMA trigger address starts a block copy of XFER_LEN bytes:
//    - source: page {data,8'h00} of the CPU address space
//    - destination: repeated writes to the OAM data port
//  The CPU is halted (cpu_rdy=0) for the whole copy. While idle, the CPU bus passes through to memory.

---
 rtl/oam_dma_ctrl.sv | 117 +++++++++++
 tb/tb_oam_dma_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_ctrl
//  Description : Sprite-RAM DMA sequencer and CPU/memory bus arbiter. A CPU
//                write to the trigger address copies one page to the OAM port.
//  Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_out,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    output logic [7:0]  cpu_data_in,
    output logic        cpu_rdy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data_out,
    output logic        mem_ren,
    output logic        mem_wen,
    input  logic [7:0]  mem_data_in,
    output logic        dma_busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HALT  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    localparam logic [8:0] C_LAST_IDX = 9'(XFER_LEN - 1);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [7:0] r_page;
    logic [8:0] r_idx;
    logic [7:0] r_byte;
    logic       r_cyc_par;
    logic       w_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_page    <= 8'h00;
            r_idx     <= 9'd0;
            r_byte    <= 8'h00;
            r_cyc_par <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cyc_par <= ~r_cyc_par;
            if (w_load) begin
                r_page <= cpu_data_out;
                r_idx  <= 9'd0;
            end
            if (r_state == S_READ) begin
                r_byte <= mem_data_in;
            end
            if (r_state == S_WRITE) begin
                r_idx <= r_idx + 9'd1;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        mem_addr     = 16'h0000;
        mem_data_out = 8'h00;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;
        cpu_data_in  = 8'h00;
        case (r_state)
            S_IDLE: begin
                // The trigger write itself still reaches memory.
                mem_addr     = cpu_addr_out;
                mem_data_out = cpu_data_out;
                mem_ren      = cpu_ren;
                mem_wen      = cpu_wen;
                cpu_data_in  = mem_data_in;
                if (cpu_wen && (cpu_addr_out == DMA_TRIG_ADDR)) begin
                    w_load = 1'b1;
                    w_next = S_HALT;
                end
            end
            S_HALT: begin
                w_next = r_cyc_par ? S_ALIGN : S_READ;
            end
            S_ALIGN: begin
                w_next = S_READ;
            end
            S_READ: begin
                // Low byte only: the source never carries into the next page.
                mem_ren  = 1'b1;
                mem_addr = {r_page, r_idx[7:0]};
                w_next   = S_WRITE;
            end
            S_WRITE: begin
                mem_wen      = 1'b1;
                mem_addr     = OAM_DATA_ADDR;
                mem_data_out = r_byte;
                w_next       = (r_idx == C_LAST_IDX) ? S_IDLE : S_READ;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign cpu_rdy  = (r_state == S_IDLE);
    assign dma_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oam_dma_ctrl
//  Description : Scoreboard bench for oam_dma_ctrl; expected bus cycles are
//                queued by the stimulus and matched by a negedge monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr_out = 16'h0000;
    logic [7:0]  cpu_data_out = 8'h00;
    logic        cpu_ren = 1'b0;
    logic        cpu_wen = 1'b0;
    logic [7:0]  cpu_data_in;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic        mem_ren;
    logic        mem_wen;
    logic [7:0]  mem_data_in;
    logic        dma_busy;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic bench_par = 1'b0;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;

    oam_dma_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr_out (cpu_addr_out),
        .cpu_data_out (cpu_data_out),
        .cpu_ren      (cpu_ren),
        .cpu_wen      (cpu_wen),
        .cpu_data_in  (cpu_data_in),
        .cpu_rdy      (cpu_rdy),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .mem_data_in  (mem_data_in),
        .dma_busy     (dma_busy)
    );

    always #5 clk = ~clk;

    // Memory contents are an address hash so every byte of a page differs.
    function automatic logic [7:0] mdl(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    assign mem_data_in = mdl(mem_addr);

    always @(posedge clk) bench_par <= rst ? 1'b0 : ~bench_par;

    always @(negedge clk) begin
        if (mon_en && (mem_ren === 1'b1 || mem_wen === 1'b1)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bus got ren=%0b wen=%0b addr=%h data=%h want no access",
                         mem_ren, mem_wen, mem_addr, mem_data_out);
            end else begin
                mon_ev = exp_q.pop_front();
                if (mem_ren !== mon_ev.ren || mem_wen !== mon_ev.wen || mem_addr !== mon_ev.addr ||
                    (mon_ev.wen && mem_data_out !== mon_ev.wdata) ||
                    (mon_ev.ren && cpu_data_in !== mon_ev.rdata)) begin
                    errors++;
                    $display("FAIL bus_event got ren=%0b wen=%0b addr=%h wdata=%h cpu_rd=%h want ren=%0b wen=%0b addr=%h wdata=%h cpu_rd=%h",
                             mem_ren, mem_wen, mem_addr, mem_data_out, cpu_data_in,
                             mon_ev.ren, mon_ev.wen, mon_ev.addr, mon_ev.wdata, mon_ev.rdata);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic push(input logic ren, input logic wen, input logic [15:0] a,
                        input logic [7:0] wd, input logic [7:0] rd);
        ev_t e;
        e.ren = ren; e.wen = wen; e.addr = a; e.wdata = wd; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_par(input logic p);
        while (bench_par != p) tick();
    endtask

    task automatic push_dma(input logic [7:0] page, input int n);
        push(1'b0, 1'b1, 16'h4014, page, 8'h00);
        for (int i = 0; i < n; i++) begin
            push(1'b1, 1'b0, {page, 8'(i)}, 8'h00, 8'h00);
            push(1'b0, 1'b1, 16'h2004, mdl({page, 8'(i)}), 8'h00);
        end
    endtask

    task automatic fire_trigger(input logic [7:0] page, input logic par);
        wait_par(par);
        cpu_wen = 1'b1; cpu_addr_out = 16'h4014; cpu_data_out = page;
        tick();
        cpu_wen = 1'b0; cpu_addr_out = 16'h0000; cpu_data_out = 8'h00;
    endtask

    task automatic run_dma(input string name, input logic [7:0] page, input logic par,
                           input int want_halt, input bit nest);
        int cnt;
        push_dma(page, 256);
        fire_trigger(page, par);
        cnt = 0;
        while (cpu_rdy === 1'b0 && cnt < 1000) begin
            cnt++;
            if (nest && cnt == 10) begin
                cpu_wen = 1'b1; cpu_addr_out = 16'h4014; cpu_data_out = 8'h55;
            end
            if (nest && cnt == 11) begin
                cpu_wen = 1'b0; cpu_addr_out = 16'h0000; cpu_data_out = 8'h00;
            end
            tick();
        end
        chk({name, "_halt_len"}, 32'(cnt), 32'(want_halt));
        chk({name, "_busy_end"}, {31'd0, dma_busy}, 32'd0);
        chk({name, "_q_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        @(negedge clk); #1;
        chk("rst_cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("rst_dma_busy", {31'd0, dma_busy}, 32'd0);
        chk("rst_mem_strobes", {30'd0, mem_ren, mem_wen}, 32'd0);
        chk("rst_cpu_data_in", {24'd0, cpu_data_in}, {24'd0, mdl(16'h0000)});
        tick();

        // T1: parity 1 at trigger, with a nested trigger attempt mid-copy
        run_dma("t1", 8'h02, 1'b1, 513, 1'b1);
        // T2: parity 0 at trigger adds one ALIGN cycle
        run_dma("t2", 8'h02, 1'b0, 514, 1'b0);

        // T3: idle read passthrough
        push(1'b1, 1'b0, 16'h0005, 8'h00, mdl(16'h0005));
        cpu_ren = 1'b1; cpu_addr_out = 16'h0005;
        @(negedge clk); #1;
        chk("t3_cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("t3_mem_addr", {16'd0, mem_addr}, 32'h0005);
        tick();
        cpu_ren = 1'b0; cpu_addr_out = 16'h0000;

        // T4: reset after 64 bytes, then restart from idx 0
        push_dma(8'h01, 64);
        fire_trigger(8'h01, 1'b1);
        guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("t4_partial_done", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        tick();
        chk("t4_rdy_after_rst", {31'd0, cpu_rdy}, 32'd1);
        chk("t4_busy_after_rst", {31'd0, dma_busy}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        run_dma("t4_restart", 8'h03, 1'b1, 513, 1'b0);

        // T5: last page, no wrap into page 0
        run_dma("t5", 8'hFF, 1'b1, 513, 1'b0);

        // T6: neighbouring write and trigger-address read are plain passthrough
        push(1'b0, 1'b1, 16'h4015, 8'h07, 8'h00);
        cpu_wen = 1'b1; cpu_addr_out = 16'h4015; cpu_data_out = 8'h07;
        tick();
        push(1'b1, 1'b0, 16'h4014, 8'h00, mdl(16'h4014));
        cpu_wen = 1'b0; cpu_ren = 1'b1; cpu_addr_out = 16'h4014; cpu_data_out = 8'h00;
        tick();
        cpu_ren = 1'b0; cpu_addr_out = 16'h0000;
        chk("t6_busy_a", {31'd0, dma_busy}, 32'd0);
        tick();
        chk("t6_busy_b", {31'd0, dma_busy}, 32'd0);

        // Trigger coincident with reset: write passes through, no DMA starts
        push(1'b0, 1'b1, 16'h4014, 8'h11, 8'h00);
        rst = 1'b1; cpu_wen = 1'b1; cpu_addr_out = 16'h4014; cpu_data_out = 8'h11;
        tick();
        rst = 1'b0; cpu_wen = 1'b0; cpu_addr_out = 16'h0000; cpu_data_out = 8'h00;
        chk("rst_trig_busy_a", {31'd0, dma_busy}, 32'd0);
        repeat (4) tick();
        chk("rst_trig_busy_b", {31'd0, dma_busy}, 32'd0);
        chk("rst_trig_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
